// File: rtl/pipeline_lca_subtractor_if.sv
// Handshake and operand/result bus for the pipelined lookahead-borrow subtractor.
// The master side is the producer/consumer pair; the slave side is the subtractor.
interface pipeline_lca_subtractor_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/pipeline_lca_subtractor.sv
// Pipelined lookahead-borrow subtractor: diff = a - b - bin (mod 2^WIDTH).
// Register index 0 captures the operands. Stage k computes slice k and writes
// register index k+1, so index STAGES holds the finished sample.
// Operands travel alongside the partial result: the copy of slice k reaching
// stage k is therefore delayed k cycles. The result bits written by stage k
// ride along to the end, which delays them STAGES-1-k cycles. All slices of one
// sample leave together. A single global enable stalls every register at once.
module pipeline_lca_subtractor #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipeline_lca_subtractor_if.slave     bus
);

  localparam int SW = WIDTH / STAGES;

  // Operand copies entering stage k.
  logic [WIDTH-1:0] op_a [STAGES];
  logic [WIDTH-1:0] op_b [STAGES];
  // Partial result, borrow and valid at register index k (0 = capture).
  logic [WIDTH-1:0] st_d  [STAGES+1];
  logic             st_br [STAGES+1];
  logic             st_v  [STAGES+1];
  logic             ovf_q;

  logic [SW-1:0]    sl_d  [STAGES];
  logic             sl_bo [STAGES];
  logic [WIDTH-1:0] nd    [STAGES];
  logic             ovf_next;
  logic             en;

  // One slice: 4-bit lookahead-borrow groups rippling group to group.
  function automatic logic [SW:0] sub_slice(input logic [SW-1:0] x,
                                            input logic [SW-1:0] y,
                                            input logic          bi);
    logic [SW-1:0] d;
    logic [3:0]    g;
    logic [3:0]    p;
    logic          grp_b;
    logic          bb;
    d     = '0;
    grp_b = bi;
    for (int n = 0; n < SW / 4; n++) begin
      g  = ~x[n*4 +: 4] & y[n*4 +: 4];
      p  = ~(x[n*4 +: 4] ^ y[n*4 +: 4]);
      bb = grp_b;
      for (int i = 0; i < 4; i++) begin
        d[n*4+i] = x[n*4+i] ^ y[n*4+i] ^ bb;
        bb       = g[i] | (p[i] & bb);
      end
      grp_b = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
              (p[3] & p[2] & p[1] & g[0]) | (&p & grp_b);
    end
    return {grp_b, d};
  endfunction

  assign en           = !st_v[STAGES] || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = st_v[STAGES];
  assign bus.diff     = st_d[STAGES];
  assign bus.bout     = st_br[STAGES];
  assign bus.ovf      = ovf_q;

  // Per-stage slice arithmetic and merge into the partial result word.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      {sl_bo[k], sl_d[k]} = sub_slice(op_a[k][k*SW +: SW], op_b[k][k*SW +: SW], st_br[k]);
      nd[k]               = st_d[k];
      nd[k][k*SW +: SW]   = sl_d[k];
    end
    ovf_next = (op_a[STAGES-1][WIDTH-1] ^ op_b[STAGES-1][WIDTH-1]) &
               (nd[STAGES-1][WIDTH-1] ^ op_a[STAGES-1][WIDTH-1]);
  end

  // Pipeline registers: capture, slice stages and output, all gated by en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        op_a[k] <= '0;
        op_b[k] <= '0;
      end
      for (int k = 0; k <= STAGES; k++) begin
        st_d[k]  <= '0;
        st_br[k] <= 1'b0;
        st_v[k]  <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (en) begin
      op_a[0]  <= bus.a;
      op_b[0]  <= bus.b;
      st_br[0] <= bus.bin;
      st_d[0]  <= '0;
      st_v[0]  <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) begin
        op_a[k] <= op_a[k-1];
        op_b[k] <= op_b[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        st_d[k+1]  <= nd[k];
        st_br[k+1] <= sl_bo[k];
        st_v[k+1]  <= st_v[k];
      end
      ovf_q <= ovf_next;
    end
  end

endmodule

// File: doc/pipeline_lca_subtractor.md
Name: pipeline_lca_subtractor

Overview:
- Pipelined lookahead-borrow subtractor. It computes diff = a - b - bin and is the subtract-side counterpart of the pipelined lookahead-carry adder.
- Operand slices are processed one per stage. Input and result skew buffers keep the bits of each sample aligned.
- A valid/ready handshake with global stall lets it sit between buffered producers and consumers in the ALU datapath.
- Output registers are built in, so no external wrapper registers are needed for timing closure.

Parameters:
- WIDTH, 64, operand and result width in bits. Must be a multiple of STAGES*4.
- STAGES, 4, number of slice stages. Each stage handles WIDTH/STAGES bits using 4-bit lookahead-borrow groups.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  minuend, unsigned or two's complement
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out; 1 iff unsigned a < b + bin
- ovf  output  1  signed overflow: sign(a) != sign(b) and sign(diff) != sign(a)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: on rst_n=0, all pipeline valid bits clear immediately. diff=0, bout=0, ovf=0, out_valid=0.
- Reset mid-operation: all in-flight samples are discarded. Nothing is emitted after release.
- Global enable: en = !out_valid || out_ready. in_ready = en, combinational. All pipeline registers, valid bits included, advance only when en=1. When en=0, every register holds.
- Accept: a sample is accepted at a rising edge with in_valid && in_ready. If in_valid=0 while en=1, a bubble (valid=0) enters. Bubbles are not collapsed.
- Stage 0 (capture edge): registers a, b, bin, and the valid bit. Slice s = bits [(s+1)*SW-1 : s*SW], where SW = WIDTH/STAGES.
- Stage k (k = 0..STAGES-1): computes slice k from its operand bits and the registered borrow from stage k-1 (stage 0 uses bin).
  - Per 4-bit group: generate g = ~a & b; propagate p = ~(a ^ b).
  - Group borrow: Bo = g3 | p3 g2 | p3 p2 g1 | p3 p2 p1 g0 | p3 p2 p1 p0 Bi.
  - Groups ripple within the slice. Difference bit = a ^ b ^ borrow_in_bit.
- Skew buffering: operand slices for stage k are delayed k cycles. Result slices from stage k are delayed STAGES-1-k cycles, so all slices of one sample leave together.
- Outputs: the final stage registers diff, bout, ovf, and out_valid.
- Latency: a sample accepted at edge N is on the outputs, with out_valid=1, after edge N+STAGES when there is no stall. Throughput is one sample per cycle.
- Stall: out_valid && !out_ready holds diff, bout, ovf, and out_valid stable. in_ready is 0 and no internal state changes.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: the result is consumed and a new sample is accepted on the same edge, with no bubble.
- Arithmetic:
  - Modulo 2^WIDTH wrap-around: 0 - 1 gives all ones with bout=1.
  - bout equals the inverse of carry-out of a + ~b + ~bin.
  - ovf is computed from full-width sign bits in the final stage.
- Order: results exit strictly in acceptance order.

Test Plan:
- Reset then single sample, no stall: a=0x10, b=0x3, bin=0 at edge 0. After edge 4: diff=0xD, bout=0, ovf=0, out_valid=1. out_valid stays 0 at edges 1-3.
- Wrap/borrow chain: a=0, b=0, bin=1. Result diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0. Exercises borrow through all slices.
- Signed overflow: a=0x8000_0000_0000_0000, b=1, bin=0. Result diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0. Also a=0x7FFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF gives diff=0x8000_0000_0000_0000, ovf=1, bout=1.
- Back-to-back stream: 100 random samples on consecutive cycles with out_ready=1. 100 results arrive in order, each matching the reference a-b-bin, with no gaps.
- Backpressure: stream random samples while out_ready toggles randomly (about 50%). Outputs stay stable while stalled, in_ready=0 while stalled, and no sample is lost or duplicated.
- Reset mid-flight: accept 3 samples, assert rst_n=0 for 1 cycle at edge 2. Outputs go to 0 and out_valid=0 immediately, and no result appears within 10 cycles after release.
